alu_pipe: RTL and testbench

//   Parametrised, handshaked successor to the 2-bit combinational ALU. Adds EOR/LSL/LSR,

---
 rtl/alu_pipe.sv | 184 ++++++++++++++++++
 tb/tb_alu_pipe.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: valid/ready handshaked ALU with registered result and ARM-style {N,Z,C,V} flags.
// Define ALU_MUL_EN to build the iterative shift-add multiplier (CALC state); otherwise MUL returns 0.
module alu_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       ALUControl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic [3:0]       ALUFlags
);
    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_ORR = 3'b011,
        OP_EOR = 3'b100,
        OP_LSL = 3'b101,
        OP_LSR = 3'b110,
        OP_MUL = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       flags_q, flags_d;

    op_e              op;
    logic [SHW-1:0]   shamt;
    logic [WIDTH:0]   add_ext, sub_ext, shl_ext, shr_ext;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v;

    assign op      = op_e'(ALUControl);
    assign shamt   = SrcB[SHW-1:0];
    assign add_ext = {1'b0, SrcA} + {1'b0, SrcB};
    // Carry out of A + ~B + 1 is the inverted borrow, i.e. C=1 iff A >= B.
    assign sub_ext = {1'b0, SrcA} + {1'b0, ~SrcB} + {{WIDTH{1'b0}}, 1'b1};
    // One guard bit on the far side of each shift catches the last bit shifted out.
    assign shl_ext = {1'b0, SrcA} << shamt;
    assign shr_ext = {SrcA, 1'b0} >> shamt;

    function automatic logic [3:0] nzcv(input logic [WIDTH-1:0] r, input logic c, input logic v);
        return {r[WIDTH-1], (r == '0), c, v};
    endfunction

    // Single-cycle operations, evaluated on the live inputs and captured on accept.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path infers a latch.
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = add_ext[WIDTH-1:0];
                alu_c   = add_ext[WIDTH];
                alu_v   = (SrcA[WIDTH-1] == SrcB[WIDTH-1]) && (alu_res[WIDTH-1] != SrcA[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = sub_ext[WIDTH-1:0];
                alu_c   = sub_ext[WIDTH];
                alu_v   = (SrcA[WIDTH-1] != SrcB[WIDTH-1]) && (alu_res[WIDTH-1] != SrcA[WIDTH-1]);
            end
            OP_AND: alu_res = SrcA & SrcB;
            OP_ORR: alu_res = SrcA | SrcB;
            OP_EOR: alu_res = SrcA ^ SrcB;
            OP_LSL: begin
                alu_res = shl_ext[WIDTH-1:0];
                alu_c   = shl_ext[WIDTH];
            end
            OP_LSR: begin
                alu_res = shr_ext[WIDTH:1];
                alu_c   = shr_ext[0];
            end
            default: alu_res = '0;
        endcase
    end

`ifdef ALU_MUL_EN
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_step;

    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        flags_d  = flags_q;
`ifdef ALU_MUL_EN
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d  = S_DONE;
                    result_d = alu_res;
                    flags_d  = nzcv(alu_res, alu_c, alu_v);
`ifdef ALU_MUL_EN
                    if (op == OP_MUL) begin
                        state_d  = S_CALC;
                        result_d = result_q;
                        flags_d  = flags_q;
                        mcand_d  = SrcA;
                        mplier_d = SrcB;
                        acc_d    = '0;
                        cnt_d    = '0;
                    end
`endif
                end
            end
            S_CALC: begin
`ifdef ALU_MUL_EN
                // One multiplier bit per cycle; only the low WIDTH bits of the product are kept.
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + SHW'(1);
                if (cnt_q == SHW'(WIDTH - 1)) begin
                    state_d  = S_DONE;
                    result_d = acc_step;
                    flags_d  = nzcv(acc_step, 1'b0, 1'b0);
                end
`else
                state_d = S_IDLE;
`endif
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!reset_n) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            flags_q  <= '0;
`ifdef ALU_MUL_EN
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            flags_q  <= flags_d;
`ifdef ALU_MUL_EN
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign ALUResult = result_q;
    assign ALUFlags  = flags_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: randomized and directed checks of alu_pipe (WIDTH=32) against a plain-arithmetic model.
// Builds with or without ALU_MUL_EN; expectations follow the macro.
module tb_alu_pipe;
    localparam int W = 32;
`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic         clk;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   alu_control;
    logic [W-1:0] src_a;
    logic [W-1:0] src_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] alu_result;
    logic [3:0]   alu_flags;

    int pass_cnt  = 0;
    int total_cnt = 0;

    alu_pipe #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ALUControl (alu_control),
        .SrcA       (src_a),
        .SrcB       (src_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ALUResult  (alu_result),
        .ALUFlags   (alu_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {N,Z,C,V,result} from ordinary 64-bit arithmetic.
    function automatic logic [35:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint unsigned ua, ub;
        longint          sa, sb, s, lim;
        int              amt;
        logic [31:0]     r;
        logic            c, v;
        ua  = a;
        ub  = b;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        lim = longint'(1) << 31;
        amt = int'(b[4:0]);
        r = '0; c = 1'b0; v = 1'b0; s = 0;
        case (op)
            3'd0: begin r = a + b; c = (ua + ub) > 64'hFFFF_FFFF; s = sa + sb; v = (s >= lim) || (s < -lim); end
            3'd1: begin r = a - b; c = (a >= b); s = sa - sb; v = (s >= lim) || (s < -lim); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: begin r = a << amt; if (amt != 0) c = a[32 - amt]; end
            3'd6: begin r = a >> amt; if (amt != 0) c = a[amt - 1]; end
            default: r = MUL_EN ? 32'(ua * ub) : 32'd0;
        endcase
        return {r[31], (r == 32'd0), c, v, r};
    endfunction

    function automatic int exp_lat(input logic [2:0] op);
        return (MUL_EN && op == 3'd7) ? W + 1 : 1;
    endfunction

    // Issue one op, wait (bounded) for the result, then take it. Inputs are scrambled after accept.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic [3:0] fl, output int lat, output bit rdy_low);
        @(negedge clk);
        in_valid = 1'b1; alu_control = op; src_a = a; src_b = b; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0; alu_control = 3'($urandom); src_a = $urandom; src_b = $urandom;
        lat = 1;
        rdy_low = 1'b1;
        while (!out_valid && lat < 200) begin
            if (in_ready) rdy_low = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (in_ready) rdy_low = 1'b0;
        res = alu_result;
        fl  = alu_flags;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        alu_control = '0; src_a = '0; src_b = '0;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if ({in_ready, out_valid} !== 2'b10)
            $display("FAIL reset handshake: in_ready/out_valid got %b%b, expected 10", in_ready, out_valid);
        else pass_cnt++;
        total_cnt++;
        if ({alu_flags, alu_result} !== 36'd0)
            $display("FAIL reset data: flags/result got %b/%h, expected 0000/00000000", alu_flags, alu_result);
        else pass_cnt++;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, r;
        logic [3:0]  f;
    } vec_t;

    task automatic test_directed();
        vec_t        v[11];
        logic [31:0] res;
        logic [3:0]  fl;
        int          lat;
        bit          rdy_low;
        v[0]  = '{3'd0, 32'd1,          32'd0,  32'd1,          4'b0000};
        v[1]  = '{3'd1, 32'd1,          32'd1,  32'd0,          4'b0110};
        v[2]  = '{3'd1, 32'd0,          32'd1,  32'hFFFF_FFFF,  4'b1000};
        v[3]  = '{3'd0, 32'h7FFF_FFFF,  32'd1,  32'h8000_0000,  4'b1001};
        v[4]  = '{3'd0, 32'hFFFF_FFFF,  32'd1,  32'd0,          4'b0110};
        v[5]  = '{3'd5, 32'h8000_0001,  32'd1,  32'd2,          4'b0010};
        v[6]  = '{3'd6, 32'd3,          32'd1,  32'd1,          4'b0010};
        v[7]  = '{3'd5, 32'd1,          32'd31, 32'h8000_0000,  4'b1000};
        v[8]  = '{3'd6, 32'h8000_0000,  32'd0,  32'h8000_0000,  4'b1000};
        v[9]  = '{3'd2, 32'h0000_F0F0,  32'h0000_0F0F, 32'd0,   4'b0100};
        v[10] = '{3'd7, 32'd7,          32'd6,  MUL_EN ? 32'd42 : 32'd0, MUL_EN ? 4'b0000 : 4'b0100};
        for (int i = 0; i < 11; i++) begin
            do_op(v[i].op, v[i].a, v[i].b, res, fl, lat, rdy_low);
            total_cnt++;
            if ({fl, res} !== {v[i].f, v[i].r})
                $display("FAIL directed[%0d] result: got %h flags %b, expected %h flags %b", i, res, fl, v[i].r, v[i].f);
            else pass_cnt++;
            total_cnt++;
            if (lat !== exp_lat(v[i].op))
                $display("FAIL directed[%0d] latency: got %0d, expected %0d", i, lat, exp_lat(v[i].op));
            else pass_cnt++;
            total_cnt++;
            if (rdy_low !== 1'b1)
                $display("FAIL directed[%0d] in_ready while busy: got high, expected low", i);
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a, b, res;
        logic [3:0]  fl;
        logic [35:0] exp;
        int          lat;
        bit          rdy_low;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = (i % 4 == 0) ? a : $urandom;
            exp = ref_alu(op, a, b);
            do_op(op, a, b, res, fl, lat, rdy_low);
            total_cnt++;
            if ({fl, res} !== exp)
                $display("FAIL random[%0d] op %0d a=%h b=%h: got %h flags %b, expected %h flags %b",
                         i, op, a, b, res, fl, exp[31:0], exp[35:32]);
            else pass_cnt++;
            total_cnt++;
            if (lat !== exp_lat(op))
                $display("FAIL random[%0d] latency op %0d: got %0d, expected %0d", i, op, lat, exp_lat(op));
            else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] a, b;
        logic [35:0] exp;
        int          lat;
        a = $urandom; b = $urandom;
        exp = ref_alu(3'd1, a, b);
        @(negedge clk);
        in_valid = 1'b1; alu_control = 3'd1; src_a = a; src_b = b; out_ready = 1'b0;
        @(posedge clk); #1;
        lat = 1;
        while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        // Keep offering a new op; it must not be taken while the result waits.
        alu_control = 3'd0;
        for (int i = 0; i < 5; i++) begin
            src_a = $urandom; src_b = $urandom;
            @(posedge clk); #1;
            total_cnt++;
            if ({out_valid, in_ready, alu_flags, alu_result} !== {2'b10, exp})
                $display("FAIL backpressure cycle %0d: valid/ready %b%b data %b/%h, expected 10 %b/%h",
                         i, out_valid, in_ready, alu_flags, alu_result, exp[35:32], exp[31:0]);
            else pass_cnt++;
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total_cnt++;
        if ({out_valid, in_ready} !== 2'b01)
            $display("FAIL backpressure release: valid/ready got %b%b, expected 01", out_valid, in_ready);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_op();
        bit saw_valid;
        @(negedge clk);
        in_valid = 1'b1; alu_control = MUL_EN ? 3'd7 : 3'd0; src_a = 32'd7; src_b = 32'd6; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (MUL_EN ? 10 : 0) @(posedge clk);
        #1;
        total_cnt++;
        if (out_valid !== !MUL_EN)
            $display("FAIL mid-op pre-reset out_valid: got %b, expected %b", out_valid, !MUL_EN);
        else pass_cnt++;
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk); #1;
        total_cnt++;
        if ({out_valid, in_ready, alu_flags, alu_result} !== {2'b01, 36'd0})
            $display("FAIL mid-op reset: valid/ready %b%b data %b/%h, expected 01 0000/00000000",
                     out_valid, in_ready, alu_flags, alu_result);
        else pass_cnt++;
        @(negedge clk);
        reset_n = 1'b1;
        saw_valid = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) saw_valid = 1'b1;
        end
        total_cnt++;
        if (saw_valid !== 1'b0)
            $display("FAIL mid-op discard: discarded op produced out_valid, expected none");
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [35:0] exp_q[$];
        logic [35:0] exp;
        logic [2:0]  op;
        logic [31:0] a, b;
        int          issued, done, cyc;
        issued = 0; done = 0; cyc = 0;
        out_ready = 1'b1;
        while (done < 10 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (out_valid) begin
                total_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL b2b unexpected result %h at cycle %0d", alu_result, cyc);
                end else begin
                    exp = exp_q.pop_front();
                    if ({alu_flags, alu_result} !== exp)
                        $display("FAIL b2b[%0d]: got %h flags %b, expected %h flags %b",
                                 done, alu_result, alu_flags, exp[31:0], exp[35:32]);
                    else pass_cnt++;
                end
                done++;
            end
            if (in_ready && issued < 10) begin
                op = 3'($urandom_range(0, 6)); a = $urandom; b = $urandom;
                in_valid = 1'b1; alu_control = op; src_a = a; src_b = b;
                exp_q.push_back(ref_alu(op, a, b));
                issued++;
            end else begin
                in_valid = 1'b0;
            end
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        total_cnt++;
        if (done !== 10 || cyc !== 20)
            $display("FAIL b2b throughput: %0d results in %0d cycles, expected 10 in 20", done, cyc);
        else pass_cnt++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid_op();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
